// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types for the branch resolve controller: FSM encoding, in-flight entry record
// and parameter defaults.
package branch_resolve_ctrl_pkg;

    localparam int QDEPTH_DEF  = 4;
    localparam int IDXW_DEF    = 2;
    // Index field is wide enough for any legal IDXW (index bits come from pc[IDXW+1:2]).
    localparam int IDX_FIELD_W = 30;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [IDX_FIELD_W-1:0] idx;
        logic [31:0]            pc4;
        logic [31:0]            target;
        logic                   pred;
    } entry_t;

endpackage

// File: rtl/br_inflight_fifo.sv
// In-flight branch queue: circular buffer with push/pop and a synchronous clear
// that takes priority over both.
module br_inflight_fifo
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  logic   clear,
    input  entry_t din,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int PTRW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNTW = PTRW + 1;

    entry_t            mem [QDEPTH];
    logic [PTRW-1:0]   wr_ptr;
    logic [PTRW-1:0]   rd_ptr;
    logic [CNTW-1:0]   count;

    assign full  = (count == CNTW'(QDEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: queues predicted branches from ID, trains the predictor
// on resolution in EX and issues a one-cycle flush/redirect on a mispredict.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEF,
    parameter int IDXW   = IDXW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_br_valid,
    input  logic [31:0]     id_pc,
    input  logic [31:0]     id_target,
    input  logic            pred_taken,
    output logic [IDXW-1:0] lookup_idx,
    output logic            id_stall,
    input  logic            ex_br_valid,
    input  logic            ex_taken,
    output logic            upd_en,
    output logic [IDXW-1:0] upd_idx,
    output logic            upd_taken,
    output logic            flush,
    output logic [31:0]     redirect_pc,
    output logic [15:0]     mispredict_cnt,
    output logic            resolve_err
);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t state;
    entry_t new_entry;
    entry_t head;
    logic   full, empty;
    logic   in_run, resolve, mispredict, push, pop;
    logic   unused_idx_bits;

    assign lookup_idx = id_pc[IDXW+1:2];
    assign in_run     = (state == ST_RUN);
    assign id_stall   = in_run && full;
    assign resolve    = in_run && ex_br_valid && !empty;
    assign mispredict = resolve && (ex_taken != head.pred);
    // A mispredict clears the queue, so a same-cycle (wrong-path) enqueue is dropped.
    assign push       = in_run && id_br_valid && !full && !mispredict;
    assign pop        = resolve && !mispredict;

    assign unused_idx_bits = ^head.idx[IDX_FIELD_W-1:IDXW];

    always_comb begin
        new_entry        = '0;
        new_entry.idx    = IDX_FIELD_W'(lookup_idx);
        new_entry.pc4    = id_pc + 32'd4;
        new_entry.target = id_target;
        new_entry.pred   = pred_taken;
    end

    br_inflight_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (mispredict),
        .din   (new_entry),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_RUN;
            upd_en         <= 1'b0;
            upd_idx        <= '0;
            upd_taken      <= 1'b0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
            resolve_err    <= 1'b0;
        end else begin
            upd_en <= resolve;
            flush  <= 1'b0;
            if (resolve) begin
                upd_idx   <= head.idx[IDXW-1:0];
                upd_taken <= ex_taken;
            end
            case (state)
                ST_RUN: begin
                    if (ex_br_valid && empty) begin
                        resolve_err <= 1'b1;
                    end
                    if (mispredict) begin
                        state          <= ST_FLUSH;
                        flush          <= 1'b1;
                        redirect_pc    <= ex_taken ? head.target : head.pc4;
                        mispredict_cnt <= sat_inc16(mispredict_cnt);
                    end
                end
                ST_FLUSH: state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

endmodule
